// File: rtl/hazard_pkg.sv
// Shared hazard-interface definitions: Tnew width, Tnew class constants, A3 width.
// Used by the Tnew pipeline and the stall controller.
package hazard_pkg;

    localparam int TNEW_W = 2;
    localparam int A3_W   = 5;

    localparam logic [TNEW_W-1:0] TNEW_NONE = 2'd0;
    localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
    localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;

endpackage

// File: rtl/tnew_stage.sv
// One pipeline register stage carrying a destination register and its Tnew.
// bubble clears the stage on capture; age_en applies a saturating Tnew decrement.
module tnew_stage
    import hazard_pkg::*;
#(
    parameter int TNEW_W = hazard_pkg::TNEW_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bubble,
    input  logic              age_en,
    input  logic [A3_W-1:0]   a3_in,
    input  logic [TNEW_W-1:0] tnew_in,
    output logic [A3_W-1:0]   a3_out,
    output logic [TNEW_W-1:0] tnew_out,
    output logic              ready
);

    localparam logic [TNEW_W-1:0] TNEW_ONE = 1;

    logic [A3_W-1:0]   a3_d,   a3_q;
    logic [TNEW_W-1:0] tnew_d, tnew_q;

    always_comb begin
        a3_d   = a3_in;
        tnew_d = tnew_in;
        // Tnew saturates at zero instead of wrapping.
        if (age_en && (tnew_in != '0)) begin
            tnew_d = tnew_in - TNEW_ONE;
        end
        if (bubble) begin
            a3_d   = '0;
            tnew_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples
    // its upstream neighbour's pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a3_q   <= '0;
            tnew_q <= '0;
        end else begin
            a3_q   <= a3_d;
            tnew_q <= tnew_d;
        end
    end

    assign a3_out   = a3_q;
    assign tnew_out = tnew_q;
    assign ready    = (a3_q != '0) && (tnew_q == '0);

endmodule

// File: rtl/tnew_pipeline.sv
// Producer side of the hazard interface: carries A3/Tnew through D/E, E/M, M/W.
// Define TNEW_PERF_CNT_EN to add the stall_cnt/issue_cnt performance counters.
module tnew_pipeline
    import hazard_pkg::*;
#(
    parameter int TNEW_W = hazard_pkg::TNEW_W
`ifdef TNEW_PERF_CNT_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [A3_W-1:0]   IDA3,
    input  logic [TNEW_W-1:0] IDTnew,
    input  logic              IDWE,
    output logic [A3_W-1:0]   DEA3,
    output logic [TNEW_W-1:0] DETnew,
    output logic [A3_W-1:0]   EMA3,
    output logic [TNEW_W-1:0] EMTnew,
    output logic [A3_W-1:0]   MWA3,
    output logic [TNEW_W-1:0] MWTnew,
    output logic              DEReady,
    output logic              EMReady,
    output logic              MWReady
`ifdef TNEW_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] issue_cnt
`endif
);

    logic              id_issue;
    logic [A3_W-1:0]   id_a3;
    logic [TNEW_W-1:0] id_tnew;

    // A write to r0 is no write at all, so its Tnew is dropped too.
    assign id_issue = IDWE && (IDA3 != '0);
    assign id_a3    = id_issue ? IDA3   : '0;
    assign id_tnew  = id_issue ? IDTnew : '0;

    tnew_stage #(.TNEW_W(TNEW_W)) u_de (
        .clk      (clk),
        .reset    (reset),
        .bubble   (stall),
        .age_en   (1'b0),
        .a3_in    (id_a3),
        .tnew_in  (id_tnew),
        .a3_out   (DEA3),
        .tnew_out (DETnew),
        .ready    (DEReady)
    );

    tnew_stage #(.TNEW_W(TNEW_W)) u_em (
        .clk      (clk),
        .reset    (reset),
        .bubble   (1'b0),
        .age_en   (1'b1),
        .a3_in    (DEA3),
        .tnew_in  (DETnew),
        .a3_out   (EMA3),
        .tnew_out (EMTnew),
        .ready    (EMReady)
    );

    tnew_stage #(.TNEW_W(TNEW_W)) u_mw (
        .clk      (clk),
        .reset    (reset),
        .bubble   (1'b0),
        .age_en   (1'b1),
        .a3_in    (EMA3),
        .tnew_in  (EMTnew),
        .a3_out   (MWA3),
        .tnew_out (MWTnew),
        .ready    (MWReady)
    );

`ifdef TNEW_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PERF_ONE = 1;

    logic [PERF_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [PERF_W-1:0] issue_cnt_d, issue_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        issue_cnt_d = issue_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + PERF_ONE;
        end else if (id_issue) begin
            issue_cnt_d = issue_cnt_q + PERF_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: doc/tnew_pipeline.md
Name: tnew_pipeline

Overview:
- Producer side of the hazard interface. Carries each instruction's destination register (A3) and Tnew through the D/E, E/M and M/W pipeline registers.
- Ages Tnew by one cycle per stage, saturating at 0.
- Inserts a D/E bubble whenever the stall controller stalls.
- Feeds DEA3/DETnew, EMA3/EMTnew and MWA3/MWTnew to the stall controller, plus per-stage ready flags to the forwarding muxes.

Parameters:
- TNEW_W, 2, width of every Tnew field.
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all stage registers.
- stall  input  1  from the stall controller; D/E captures a bubble this cycle.
- IDA3  input  5  destination register decoded in ID.
- IDTnew  input  TNEW_W  Tnew of the ID instruction, expressed as the value it will have in E.
- IDWE  input  1  ID instruction writes the GPR file.
- DEA3  output  5  E-stage destination; 0 = no write.
- DETnew  output  TNEW_W  E-stage Tnew.
- EMA3  output  5  M-stage destination.
- EMTnew  output  TNEW_W  M-stage Tnew.
- MWA3  output  5  W-stage destination.
- MWTnew  output  TNEW_W  W-stage Tnew.
- DEReady  output  1  DEA3!=0 and DETnew==0; result forwardable from E.
- EMReady  output  1  EMA3!=0 and EMTnew==0.
- MWReady  output  1  MWA3!=0 and MWTnew==0.

Behaviour:
- Reset (async, active-high): all A3 and Tnew registers go to 0 immediately, which makes all Ready flags 0. Counters also clear. Reset mid-pipeline discards every in-flight entry. No outputs are X after reset.
- Register stages are D/E, E/M and M/W. No valid bit is kept: A3==0 means empty or no-write.
- D/E capture each clock:
  - stall=1: DEA3<=0, DETnew<=0 (bubble).
  - otherwise: DEA3 <= IDWE ? IDA3 : 0; DETnew <= IDWE ? IDTnew : 0.
  - IDA3==0 with IDWE=1 is stored as A3=0, and its Tnew is forced to 0.
- E/M capture: EMA3<=DEA3; EMTnew <= (DETnew==0) ? 0 : DETnew-1.
- M/W capture: MWA3<=EMA3; MWTnew <= (EMTnew==0) ? 0 : EMTnew-1.
- Saturation:
  - Tnew never wraps; a value of 0 stays 0.
  - Legal IDTnew range is 0..2. An input of 3 is accepted and ages to 2, then 1.
- Stall does not freeze E/M or M/W; downstream stages always advance.
- A stall held for N cycles inserts N consecutive bubbles.
- Latency: ID values appear on DE* 1 cycle after the edge; on EM* after 2 cycles; on MW* after 3 cycles.
- Ready flags are purely combinational from the stage registers.
- Same A3 in several stages is legal. Priority (E over M over W) is the consumer's job; this block outputs every stage unchanged.

Optional Feature:
- Macro: TNEW_PERF_CNT_EN.
- Defined: adds output stall_cnt [PERF_W-1:0] and output issue_cnt [PERF_W-1:0].
  - stall_cnt increments on every clock with stall=1.
  - issue_cnt increments on every non-stall clock with IDWE=1 and IDA3!=0.
  - Both wrap modulo 2^PERF_W.
  - Both clear on reset.
- Not defined: these ports and registers do not exist. Remaining behaviour is identical.

Decomposition:
- Shared package (hazard_pkg): TNEW_W, the Tnew constants TNEW_ALU=1, TNEW_LOAD=2 and TNEW_NONE=0, and the A3 width constant 5. The stall controller uses the same package.
- One natural sub-module: tnew_stage. One register stage (A3 + Tnew) with inputs bubble and age_en: age_en=1 applies the saturating decrement, age_en=0 passes Tnew through.
  - Instantiated 3 times: D/E with age_en=0 and bubble=stall; E/M and M/W with age_en=1 and bubble=0.

Test Plan:
1. Reset: assert reset mid-cycle with non-zero state -> all six A3/Tnew outputs and Ready flags read 0 before the next edge.
2. lw: IDA3=8, IDTnew=2, IDWE=1, no stall -> next three cycles show DE(8,2), EM(8,1), MW(8,0); MWReady=1 only in the third cycle.
3. ALU: IDA3=9, IDTnew=1 -> DE(9,1) DEReady=0, then EM(9,0) EMReady=1, then MW(9,0).
4. Stall for 2 cycles after a lw: 2 bubbles, DE(0,0) twice, while the lw continues to EM and then MW unchanged.
5. IDWE=0 with IDA3=5 and IDTnew=2, and separately IDWE=1 with IDA3=0 -> DE(0,0) in both cases; no Ready flag asserts.
6. With TNEW_PERF_CNT_EN: 3 stall cycles and 4 issuing writes -> stall_cnt=3, issue_cnt=4. With PERF_W=4, start from 15 and count once more -> the counter wraps to 0.
